// File: rtl/slicer_axil_regs.sv
// AXI4-Lite register file for the slicer IP: four 32-bit byte-strobed config registers.
// Optional out-of-range SLVERR decoding is enabled with `define SLICER_AXIL_SLVERR_EN.
module slicer_axil_regs #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      S_AXI_ACLK,
  input  logic                      S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                S_AXI_AWPROT,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                S_AXI_ARPROT,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY,
  output logic [DATA_WIDTH-1:0]     slv_reg0,
  output logic [DATA_WIDTH-1:0]     slv_reg1,
  output logic [DATA_WIDTH-1:0]     slv_reg2,
  output logic [DATA_WIDTH-1:0]     slv_reg3,
  output logic [3:0]                reg_wr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int NUM_REGS   = 4;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  aw_full_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic                  w_full_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic [3:0]            reg_wr_q;

  logic                  arready_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  commit;
  logic                  aw_full_n;
  logic                  w_full_n;
  logic                  bvalid_n;
  logic                  rvalid_n;
  logic [1:0]            wr_sel;
  logic [1:0]            rd_sel;
  logic [3:0]            wr_onehot;
  logic                  aw_oor;
  logic                  ar_oor;
  logic                  unused_ok;

  // Ready flags are registered, so they are derived from next-state buffer/response status.
  always_comb begin
    aw_hs     = S_AXI_AWVALID && awready_q;
    w_hs      = S_AXI_WVALID && wready_q;
    b_hs      = bvalid_q && S_AXI_BREADY;
    ar_hs     = S_AXI_ARVALID && arready_q;
    r_hs      = rvalid_q && S_AXI_RREADY;
    commit    = aw_full_q && w_full_q;
    aw_full_n = commit ? 1'b0 : (aw_full_q || aw_hs);
    w_full_n  = commit ? 1'b0 : (w_full_q || w_hs);
    bvalid_n  = commit ? 1'b1 : (b_hs ? 1'b0 : bvalid_q);
    rvalid_n  = ar_hs ? 1'b1 : (r_hs ? 1'b0 : rvalid_q);
    wr_sel    = aw_addr_q[3:2];
    rd_sel    = S_AXI_ARADDR[3:2];
    wr_onehot = 4'b0001 << wr_sel;
  end

`ifdef SLICER_AXIL_SLVERR_EN
  assign aw_oor = (aw_addr_q >> 4) != '0;
  assign ar_oor = (S_AXI_ARADDR >> 4) != '0;
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_addr_q, S_AXI_ARADDR};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      reg_wr_q  <= '0;
    end else begin
      if (aw_hs) begin
        aw_addr_q <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      aw_full_q <= aw_full_n;
      w_full_q  <= w_full_n;
      bvalid_q  <= bvalid_n;
      awready_q <= !aw_full_n && !bvalid_n;
      wready_q  <= !w_full_n && !bvalid_n;
      if (commit) begin
        bresp_q <= aw_oor ? 2'b10 : 2'b00;
      end
      reg_wr_q <= (commit && !aw_oor) ? wr_onehot : 4'b0000;
    end
  end

  // A zero strobe still commits and pulses reg_wr, it just leaves every lane untouched.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int n = 0; n < NUM_REGS; n++) begin
        regs_q[n] <= '0;
      end
    end else if (commit && !aw_oor) begin
      for (int n = 0; n < NUM_REGS; n++) begin
        if (wr_onehot[n]) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (w_strb_q[b]) begin
              regs_q[n][8*b +: 8] <= w_data_q[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Read data is sampled on the handshake edge, so a same-edge commit is not yet visible.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      rvalid_q  <= rvalid_n;
      arready_q <= !rvalid_n;
      if (ar_hs) begin
        rdata_q <= ar_oor ? '0 : regs_q[rd_sel];
        rresp_q <= ar_oor ? 2'b10 : 2'b00;
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign slv_reg0      = regs_q[0];
  assign slv_reg1      = regs_q[1];
  assign slv_reg2      = regs_q[2];
  assign slv_reg3      = regs_q[3];
  assign reg_wr        = reg_wr_q;

endmodule
